// File: rtl/joypad_pkg.sv
// Shared types and constants for the Genesis-to-NES joypad scanner.
//   scan_state_t  : scan FSM states
//   nes_buttons_t : active-high NES button vector
//   BTN_*         : NES bit positions inside nes_buttons_t
//   PIN_*         : Genesis pad pin positions (D5..D0) for each select phase
//   decode_pad    : raw active-low phase-H/phase-L pins -> NES vector
//   pad_present   : pad detection from the phase-L pins
package joypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEL_HI  = 2'd1,
    ST_SEL_LO  = 2'd2,
    ST_RESOLVE = 2'd3
  } scan_state_t;

  typedef logic [7:0] nes_buttons_t;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Phase-H (select high) pins
  localparam int unsigned PIN_UP      = 0;
  localparam int unsigned PIN_DOWN    = 1;
  localparam int unsigned PIN_LEFT    = 2;
  localparam int unsigned PIN_RIGHT   = 3;
  localparam int unsigned PIN_H_B     = 4;
  localparam int unsigned PIN_H_C     = 5;
  // Phase-L (select low) pins; D2/D3 are tied low by a connected pad
  localparam int unsigned PIN_L_ID0   = 2;
  localparam int unsigned PIN_L_ID1   = 3;
  localparam int unsigned PIN_L_A     = 4;
  localparam int unsigned PIN_L_START = 5;

  function automatic logic pad_present(input logic [5:0] l_pins);
    return !l_pins[PIN_L_ID0] && !l_pins[PIN_L_ID1];
  endfunction

  function automatic nes_buttons_t decode_pad(input logic [5:0] h_pins,
                                              input logic [5:0] l_pins);
    nes_buttons_t v;
    logic [5:0]   h_act;
    logic [5:0]   l_act;
    h_act = ~h_pins;
    l_act = ~l_pins;
    v = '0;
    v[BTN_A]      = h_act[PIN_H_B];
    v[BTN_B]      = l_act[PIN_L_A];
    v[BTN_SELECT] = h_act[PIN_H_C];
    v[BTN_START]  = l_act[PIN_L_START];
    v[BTN_UP]     = h_act[PIN_UP];
    v[BTN_DOWN]   = h_act[PIN_DOWN];
    v[BTN_LEFT]   = h_act[PIN_LEFT];
    v[BTN_RIGHT]  = h_act[PIN_RIGHT];
    if (!pad_present(l_pins)) begin
      v = '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/pad_debounce.sv
// Per-port debouncer: a decoded vector must be seen on DEBOUNCE_COUNT
// consecutive scans before it replaces the output vector.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_scan         : one-cycle strobe, i_decoded holds a fresh scan result
//   i_decoded      : decoded NES vector of this scan
//   o_buttons      : debounced NES vector
//   o_valid        : one-cycle pulse (cycle after i_scan) when o_buttons changes
module pad_debounce
  import joypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_scan,
  input  nes_buttons_t i_decoded,
  output nes_buttons_t o_buttons,
  output logic         o_valid
);

  localparam int unsigned      CW      = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_COUNT);

  nes_buttons_t  r_cand;
  nes_buttons_t  w_cand_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  // The output decision uses the post-scan count so that the DEBOUNCE_COUNT-th
  // identical scan itself updates the output.
  always_comb begin
    w_cand_next  = r_cand;
    w_count_next = r_count;
    if (i_decoded != r_cand) begin
      w_cand_next  = i_decoded;
      w_count_next = CW'(1);
    end else if (r_count != CNT_MAX) begin
      w_count_next = r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand    <= '0;
      r_count   <= '0;
      o_buttons <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_scan) begin
        r_cand  <= w_cand_next;
        r_count <= w_count_next;
        if ((w_count_next == CNT_MAX) && (w_cand_next != o_buttons)) begin
          o_buttons <= w_cand_next;
          o_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/joypad_scanner.sv
// Scans two Genesis 6-pin pads by toggling select, samples each phase at the
// end of its settle window, decodes to NES button order and debounces.
//   I_clock      : system clock
//   I_reset      : async active-low reset
//   I_pad_pins   : raw active-low pad pins D5..D0 per port (asynchronous)
//   O_pad_select : select line to both pads (identical)
//   O_buttons    : debounced active-high NES vector per port
//   O_valid      : one-cycle pulse per port when O_buttons changes
//   O_present    : pad detected on each port, refreshed every scan
module joypad_scanner
  import joypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned DEBOUNCE_COUNT = 4,
  parameter int unsigned SCAN_PERIOD    = 16384
) (
  input  logic            I_clock,
  input  logic            I_reset,
  input  logic [1:0][5:0] I_pad_pins,
  output logic [1:0]      O_pad_select,
  output logic [1:0][7:0] O_buttons,
  output logic [1:0]      O_valid,
  output logic [1:0]      O_present
);

  if (SCAN_PERIOD <= 2 * SETTLE_CYCLES + 2) begin : g_bad_period
    $error("joypad_scanner: SCAN_PERIOD must exceed 2*SETTLE_CYCLES+2");
  end
  if (DEBOUNCE_COUNT < 1) begin : g_bad_debounce
    $error("joypad_scanner: DEBOUNCE_COUNT must be at least 1");
  end

  localparam int unsigned   PW         = $clog2(SCAN_PERIOD);
  localparam int unsigned   SW         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_MAX = PW'(SCAN_PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);

  scan_state_t           r_state;
  scan_state_t           w_state_next;
  logic [PW-1:0]         r_period;
  logic [SW-1:0]         r_settle;
  logic [1:0][5:0]       r_sync1;
  logic [1:0][5:0]       r_sync2;
  logic [1:0][5:0]       r_phase_h;
  logic [1:0][5:0]       r_phase_l;
  logic                  w_select;
  logic                  w_start;
  logic                  w_settling;
  logic                  w_cap_h;
  logic                  w_cap_l;
  logic                  w_scan;
  nes_buttons_t [1:0]    w_decoded;
  logic [1:0]            w_present;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= I_pad_pins;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_select     = 1'b1;
    w_start      = 1'b0;
    w_settling   = 1'b0;
    w_cap_h      = 1'b0;
    w_cap_l      = 1'b0;
    w_scan       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_period == PERIOD_MAX) begin
          w_start      = 1'b1;
          w_state_next = ST_SEL_HI;
        end
      end
      ST_SEL_HI: begin
        w_settling = 1'b1;
        if (r_settle == SETTLE_MAX) begin
          w_cap_h      = 1'b1;
          w_state_next = ST_SEL_LO;
        end
      end
      ST_SEL_LO: begin
        w_select   = 1'b0;
        w_settling = 1'b1;
        if (r_settle == SETTLE_MAX) begin
          w_cap_l      = 1'b1;
          w_state_next = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        w_scan       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The period counter runs freely through the whole scan and only restarts
  // when a new scan begins, so scan starts are exactly SCAN_PERIOD apart.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_state   <= ST_IDLE;
      r_period  <= '0;
      r_settle  <= '0;
      r_phase_h <= '1;
      r_phase_l <= '1;
      O_present <= '0;
    end else begin
      r_state  <= w_state_next;
      r_period <= w_start ? '0 : r_period + 1'b1;
      r_settle <= (w_settling && (r_settle != SETTLE_MAX)) ? r_settle + 1'b1 : '0;
      if (w_cap_h) begin
        r_phase_h <= r_sync2;
      end
      if (w_cap_l) begin
        r_phase_l <= r_sync2;
      end
      if (w_scan) begin
        O_present <= w_present;
      end
    end
  end

  always_comb begin
    w_decoded = '0;
    w_present = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      w_decoded[p] = decode_pad(r_phase_h[p], r_phase_l[p]);
      w_present[p] = pad_present(r_phase_l[p]);
    end
  end

  assign O_pad_select = {2{w_select}};

  pad_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_deb0 (
    .i_clk     (I_clock),
    .i_rst_n   (I_reset),
    .i_scan    (w_scan),
    .i_decoded (w_decoded[0]),
    .o_buttons (O_buttons[0]),
    .o_valid   (O_valid[0])
  );

  pad_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_deb1 (
    .i_clk     (I_clock),
    .i_rst_n   (I_reset),
    .i_scan    (w_scan),
    .i_decoded (w_decoded[1]),
    .o_buttons (O_buttons[1]),
    .o_valid   (O_valid[1])
  );

endmodule

// File: tb/tb_joypad_scanner.sv
// Self-checking bench for joypad_scanner. Two pads are modelled as a select-
// driven mux of per-phase pin patterns; a reference model decodes each scan
// from the pin-map table and debounces with a history of recent scans.
module tb_joypad_scanner;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned DEBN   = 3;
  localparam int unsigned PERIOD = 32;

  // NES bit b comes from phase SRC_PHASE[b] (0=H, 1=L), pin SRC_PIN[b]
  localparam int unsigned SRC_PHASE [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
  localparam int unsigned SRC_PIN   [8] = '{4, 4, 5, 5, 0, 1, 2, 3};

  logic            clk = 1'b0;
  logic            I_reset;
  logic [1:0][5:0] pins;
  logic [1:0]      O_pad_select;
  logic [1:0][7:0] O_buttons;
  logic [1:0]      O_valid;
  logic [1:0]      O_present;

  logic [5:0]      pad_h [2];
  logic [5:0]      pad_l [2];
  logic            glitch_en = 1'b0;
  logic [1:0][5:0] glitch_val = '1;

  int unsigned     tests = 0;
  int unsigned     fails = 0;
  int unsigned     vcnt [2] = '{0, 0};
  int unsigned     exp_pulses [2] = '{0, 0};
  logic [7:0]      exp_out [2] = '{8'h00, 8'h00};
  logic [1:0]      exp_present = '0;
  logic [1:0]      exp_valid = '0;
  logic [7:0]      hist [2][$];
  time             last_fall = 0;
  bit              have_fall = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (glitch_en) pins[p] = glitch_val[p];
      else           pins[p] = O_pad_select[p] ? pad_h[p] : pad_l[p];
    end
  end

  always @(posedge clk) begin
    if (O_valid[0] === 1'b1) vcnt[0] = vcnt[0] + 1;
    if (O_valid[1] === 1'b1) vcnt[1] = vcnt[1] + 1;
  end

  joypad_scanner #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_COUNT (DEBN),
    .SCAN_PERIOD    (PERIOD)
  ) dut (
    .I_clock      (clk),
    .I_reset      (I_reset),
    .I_pad_pins   (pins),
    .O_pad_select (O_pad_select),
    .O_buttons    (O_buttons),
    .O_valid      (O_valid),
    .O_present    (O_present)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_decode(input logic [5:0] h, input logic [5:0] l);
    logic [7:0] v;
    v = 8'h00;
    if (l[2] == 1'b0 && l[3] == 1'b0) begin
      for (int b = 0; b < 8; b++)
        v[b] = (SRC_PHASE[b] == 0) ? ~h[SRC_PIN[b]] : ~l[SRC_PIN[b]];
    end
    return v;
  endfunction

  task automatic model_scan();
    logic [7:0] d;
    bit         same;
    for (int p = 0; p < 2; p++) begin
      d = model_decode(pad_h[p], pad_l[p]);
      exp_present[p] = (pad_l[p][2] == 1'b0) && (pad_l[p][3] == 1'b0);
      hist[p].push_back(d);
      if (hist[p].size() > DEBN) void'(hist[p].pop_front());
      same = (hist[p].size() == DEBN);
      foreach (hist[p][i]) if (hist[p][i] != d) same = 1'b0;
      exp_valid[p] = 1'b0;
      if (same && d != exp_out[p]) begin
        exp_out[p]    = d;
        exp_valid[p]  = 1'b1;
        exp_pulses[p] = exp_pulses[p] + 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      hist[p].delete();
      exp_out[p] = 8'h00;
    end
    exp_present = '0;
    have_fall   = 1'b0;
  endtask

  task automatic wait_sel(input logic lvl, input int unsigned bound,
                          output int unsigned n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (O_pad_select === {2{lvl}}) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_scan(input bit after_reset);
    int unsigned n;
    bit          ok;
    time         tf;
    wait_sel(1'b0, PERIOD + SETTLE + 8, n, ok);
    check("scan_start_seen", 32'(ok), 32'd1);
    tf = $time;
    if (after_reset) check("first_scan_delay", n, PERIOD + SETTLE);
    else if (have_fall) check("scan_period", 32'((tf - last_fall) / 10), PERIOD);
    last_fall = tf;
    have_fall = 1'b1;
    wait_sel(1'b1, SETTLE + 4, n, ok);
    check("sel_low_end_seen", 32'(ok), 32'd1);
    check("sel_low_len", n, SETTLE);
    model_scan();
    @(negedge clk);
    check("valid", 32'(O_valid), 32'(exp_valid));
    check("buttons0", 32'(O_buttons[0]), 32'(exp_out[0]));
    check("buttons1", 32'(O_buttons[1]), 32'(exp_out[1]));
    check("present", 32'(O_present), 32'(exp_present));
    glitch_val = {6'($urandom), 6'($urandom)};
    glitch_en  = 1'b1;
    repeat (3) @(negedge clk);
    glitch_en  = 1'b0;
    check("pulses0", vcnt[0], exp_pulses[0]);
    check("pulses1", vcnt[1], exp_pulses[1]);
  endtask

  task automatic set_pads(input logic [5:0] h0, input logic [5:0] l0,
                          input logic [5:0] h1, input logic [5:0] l1);
    pad_h[0] = h0; pad_l[0] = l0;
    pad_h[1] = h1; pad_l[1] = l1;
  endtask

  initial begin
    int unsigned n;
    bit          ok;
    int unsigned hold;
    logic [5:0]  rh [2];
    logic [5:0]  rl [2];

    I_reset = 1'b0;
    set_pads(6'h3F, 6'h3F, 6'h3F, 6'h3F);
    repeat (3) @(negedge clk);
    check("rst_select", 32'(O_pad_select), 32'h3);
    check("rst_buttons", 32'(O_buttons), 32'h0);
    check("rst_valid", 32'(O_valid), 32'h0);
    check("rst_present", 32'(O_present), 32'h0);
    I_reset = 1'b1;
    run_scan(1'b1);

    // no pad on either port
    repeat (3) run_scan(1'b0);

    // port0 holds Start
    set_pads(6'h3F, 6'h13, 6'h3F, 6'h3F);
    repeat (5) run_scan(1'b0);
    check("start_held", 32'(O_buttons[0]), 32'h08);

    // release with the pad still connected
    set_pads(6'h3F, 6'h33, 6'h3F, 6'h3F);
    repeat (4) run_scan(1'b0);
    check("released", 32'(O_buttons[0]), 32'h00);

    // Start toggled every scan never settles
    for (int i = 0; i < 6; i++) begin
      set_pads(6'h3F, (i % 2 == 0) ? 6'h13 : 6'h33, 6'h3F, 6'h3F);
      run_scan(1'b0);
    end
    check("toggle_buttons", 32'(O_buttons[0]), 32'h00);

    // port0 Up, port1 Right+B
    set_pads(6'h3E, 6'h32, 6'h27, 6'h33);
    repeat (4) run_scan(1'b0);
    check("up_port0", 32'(O_buttons[0]), 32'h10);
    check("rightb_port1", 32'(O_buttons[1]), 32'h81);

    // asynchronous reset in the middle of the select-low phase
    wait_sel(1'b0, PERIOD + SETTLE + 8, n, ok);
    check("pre_reset_fall_seen", 32'(ok), 32'd1);
    @(negedge clk);
    #2 I_reset = 1'b0;
    #1;
    check("midrst_select", 32'(O_pad_select), 32'h3);
    check("midrst_buttons", 32'(O_buttons), 32'h0);
    check("midrst_valid", 32'(O_valid), 32'h0);
    check("midrst_present", 32'(O_present), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    I_reset = 1'b1;
    run_scan(1'b1);

    // randomised patterns, each held for a random number of scans
    for (int k = 0; k < 30; k++) begin
      for (int p = 0; p < 2; p++) begin
        rh[p] = 6'($urandom);
        if ($urandom_range(0, 3) == 0) rl[p] = 6'($urandom) | 6'h04;
        else rl[p] = {2'($urandom), 2'b00, 2'($urandom)};
      end
      set_pads(rh[0], rl[0], rh[1], rl[1]);
      hold = $urandom_range(1, 4);
      repeat (hold) run_scan(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
